// File: rtl/csi_lane_aligner.sv
// Per-lane deskew ahead of the CSI-2 byte inputs: delays each lane so all
// enabled lanes present their first HS byte in the same cycle.
module csi_lane_aligner #(
   parameter int NUM_LANES  = 4,
   parameter int LANE_WIDTH = 8,
   parameter int MAX_SKEW   = 3
) (
   input  logic                            byte_clk_i,
   input  logic                            reset_i,
   input  logic [NUM_LANES-1:0]            lane_en_i,
   input  logic [NUM_LANES-1:0]            lane_valid_i,
   input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_data_i,
   output logic [NUM_LANES-1:0]            aligned_valid_o,
   output logic [NUM_LANES*LANE_WIDTH-1:0] aligned_data_o,
   output logic                            skew_err_o,
   output logic                            aligned_o
);
   localparam int TW = $clog2(MAX_SKEW + 1);
   localparam int CW = $clog2(MAX_SKEW + 2);
   localparam logic [CW-1:0] RUN_MAX  = CW'(MAX_SKEW + 1);
   localparam logic [CW-1:0] SKEW_LIM = CW'(MAX_SKEW);

   typedef enum logic [1:0] {IDLE, ALIGN, STREAM, ERR} state_t;
   typedef logic [LANE_WIDTH:0] ent_t;

   state_t state_q, state_d;
   logic [NUM_LANES-1:0] en_q, en_d, en_eff, vld, drop, tv;
   logic [CW-1:0] run_q   [NUM_LANES];
   logic [CW-1:0] run_cur [NUM_LANES];
   logic [CW-1:0] skew_q, skew_d, skew_cur;
   logic [TW-1:0] tap_q   [NUM_LANES];
   logic [TW-1:0] tap_new [NUM_LANES];
   logic [TW-1:0] tap_sel [NUM_LANES];
   ent_t dl_q [NUM_LANES][MAX_SKEW];
   ent_t sr   [NUM_LANES][MAX_SKEW+1];
   logic [NUM_LANES*LANE_WIDTH-1:0] td;
   logic load, err_d, tap_upd;

   // sr[i][0] is the live input; deeper entries come from the delay line
   always_comb begin
      en_eff   = (state_q == IDLE) ? lane_en_i : en_q;
      vld      = lane_valid_i & en_eff;
      skew_cur = skew_q + 1'b1;
      drop     = '0;
      tv       = '0;
      td       = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (!vld[i])                  run_cur[i] = '0;
         else if (state_q == IDLE)     run_cur[i] = CW'(1);
         else if (run_q[i] == RUN_MAX) run_cur[i] = RUN_MAX;
         else                          run_cur[i] = run_q[i] + 1'b1;
         drop[i] = (run_q[i] != '0) && !vld[i];
         if (state_q == ALIGN && run_cur[i] != '0)
            tap_new[i] = TW'(run_cur[i] - 1'b1);
         else
            tap_new[i] = '0;
         tap_sel[i] = (state_q == STREAM) ? tap_q[i] : tap_new[i];
         sr[i][0] = {lane_valid_i[i], lane_data_i[i*LANE_WIDTH +: LANE_WIDTH]};
         for (int k = 1; k <= MAX_SKEW; k++)
            sr[i][k] = dl_q[i][k-1];
         tv[i] = sr[i][tap_sel[i]][LANE_WIDTH] & en_eff[i];
         if (en_eff[i])
            td[i*LANE_WIDTH +: LANE_WIDTH] = sr[i][tap_sel[i]][LANE_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      skew_d  = skew_q;
      load    = 1'b0;
      err_d   = 1'b0;
      tap_upd = 1'b0;
      unique case (state_q)
         IDLE: begin
            en_d   = lane_en_i;
            skew_d = '0;
            if (|vld) begin
               if (vld == lane_en_i) begin
                  state_d = STREAM;
                  load    = 1'b1;
                  tap_upd = 1'b1;
               end else begin
                  state_d = ALIGN;
               end
            end
         end
         ALIGN: begin
            skew_d = skew_cur;
            if (vld == en_q) begin
               state_d = STREAM;
               load    = 1'b1;
               tap_upd = 1'b1;
            end else if (|drop || skew_cur >= SKEW_LIM) begin
               state_d = ERR;
               err_d   = 1'b1;
            end
         end
         STREAM: begin
            load = 1'b1;
            if (tv == '0) state_d = IDLE;
         end
         ERR: begin
            if (vld == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge byte_clk_i) begin
      if (reset_i) begin
         state_q         <= IDLE;
         en_q            <= '0;
         skew_q          <= '0;
         aligned_valid_o <= '0;
         aligned_data_o  <= '0;
         skew_err_o      <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            run_q[i] <= '0;
            tap_q[i] <= '0;
            for (int k = 0; k < MAX_SKEW; k++)
               dl_q[i][k] <= '0;
         end
      end else begin
         state_q         <= state_d;
         en_q            <= en_d;
         skew_q          <= skew_d;
         aligned_valid_o <= load ? tv : '0;
         aligned_data_o  <= load ? td : '0;
         skew_err_o      <= err_d;
         for (int i = 0; i < NUM_LANES; i++) begin
            run_q[i] <= run_cur[i];
            if (tap_upd) tap_q[i] <= tap_new[i];
            dl_q[i][0] <= sr[i][0];
            for (int k = 1; k < MAX_SKEW; k++)
               dl_q[i][k] <= dl_q[i][k-1];
         end
      end
   end

   assign aligned_o = (state_q == STREAM);

endmodule

// File: tb/tb_csi_lane_aligner.sv
// Bench for csi_lane_aligner: directed and random bursts checked against
// a burst-level model of when each lane's bytes must emerge.
module tb_csi_lane_aligner;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en, vin;
   logic [31:0] din;
   logic [3:0]  av;
   logic [31:0] ad;
   logic        serr, al;

   int total = 0;
   int bad   = 0;
   int ss [4];
   int ll [4];
   logic [7:0] dat [64][4];

   always #5 clk = ~clk;

   csi_lane_aligner dut (
      .byte_clk_i      (clk),
      .reset_i         (rst),
      .lane_en_i       (en),
      .lane_valid_i    (vin),
      .lane_data_i     (din),
      .aligned_valid_o (av),
      .aligned_data_o  (ad),
      .skew_err_o      (serr),
      .aligned_o       (al)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit va(input int i, input int t);
      return (t >= ss[i]) && (t < ss[i] + ll[i]);
   endfunction

   // Model: find the cycle where all enabled lanes are first valid (S) or
   // where alignment must fail (errc), then place bytes at S+1+j.
   task automatic burst(input string name, input logic [3:0] e,
                        input bit tog, input bit rnd,
                        input logic [7:0] base, input int rst_at);
      int S, errc, mx, last, n, c, j;
      bit allv, drop, live;
      logic [3:0] ev;
      logic eal, eerr;
      S = -1; errc = -1; mx = 0; last = 0;
      for (int i = 0; i < 4; i++)
         if (e[i]) begin
            if (ll[i] > mx) mx = ll[i];
            if (ss[i] + ll[i] > last) last = ss[i] + ll[i];
         end
      for (int t = 0; t <= 3; t++) begin
         if (S < 0 && errc < 0) begin
            allv = 1'b1; drop = 1'b0;
            for (int i = 0; i < 4; i++)
               if (e[i]) begin
                  if (!va(i, t)) allv = 1'b0;
                  if (t > 0 && va(i, t-1) && !va(i, t)) drop = 1'b1;
               end
            if (allv) S = t;
            else if (t > 0 && (drop || t == 3)) errc = t;
         end
      end
      n = last + 6;
      en = e;
      for (int t = 0; t < n; t++) begin
         for (int i = 0; i < 4; i++) begin
            if (e[i]) vin[i] = va(i, t);
            else      vin[i] = tog ? 1'($urandom_range(0, 1)) : 1'b0;
            dat[t][i] = rnd ? 8'($urandom) : base + 8'(16 * i) + 8'(t - ss[i]);
            din[8*i +: 8] = dat[t][i];
         end
         if (rst_at >= 0 && t >= rst_at) vin = '0;
         rst = (t == rst_at);
         @(posedge clk);
         #1;
         c = t + 1;
         live = !(rst_at >= 0 && c > rst_at);
         ev = '0; eal = 1'b0; eerr = 1'b0;
         if (live && S >= 0) begin
            eal = (c > S) && (c <= S + mx);
            for (int i = 0; i < 4; i++) begin
               j = c - 1 - S;
               if (e[i] && j >= 0 && j < ll[i]) ev[i] = 1'b1;
            end
         end
         if (live && errc >= 0 && c == errc + 1) eerr = 1'b1;
         chk($sformatf("%s.valid c%0d", name, c), 32'(av), 32'(ev));
         chk($sformatf("%s.aligned c%0d", name, c), 32'(al), 32'(eal));
         chk($sformatf("%s.skew_err c%0d", name, c), 32'(serr), 32'(eerr));
         for (int i = 0; i < 4; i++) begin
            if (ev[i])
               chk($sformatf("%s.data%0d c%0d", name, i, c),
                   32'(ad[8*i +: 8]), 32'(dat[ss[i] + c - 1 - S][i]));
            else if (!e[i])
               chk($sformatf("%s.offdata%0d c%0d", name, i, c),
                   32'(ad[8*i +: 8]), 32'(0));
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      int f, g, mxs;
      bit ovf;
      logic [3:0] e;
      rst = 1'b1; en = '0; vin = '0; din = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.valid", 32'(av), 32'(0));
      chk("reset.data", ad, 32'(0));
      chk("reset.err", 32'(serr), 32'(0));
      chk("reset.aligned", 32'(al), 32'(0));
      rst = 1'b0;

      // all lanes disabled: raw valids must never start a burst
      en = 4'h0; vin = 4'hF; din = 32'hDEADBEEF;
      for (int t = 0; t < 4; t++) begin
         @(posedge clk);
         #1;
         chk($sformatf("noen.aligned c%0d", t), 32'(al), 32'(0));
         chk($sformatf("noen.valid c%0d", t), 32'(av), 32'(0));
      end
      vin = '0;
      repeat (2) @(posedge clk);
      #1;

      ss = '{0, 0, 0, 0}; ll = '{8, 8, 8, 8};
      burst("zero", 4'hF, 1'b0, 1'b0, 8'h00, -1);

      ss = '{0, 1, 2, 3}; ll = '{6, 6, 6, 6};
      burst("maxskew", 4'hF, 1'b0, 1'b0, 8'hB8, -1);

      ss = '{0, 1, 2, 4}; ll = '{8, 7, 6, 4};
      burst("overflow", 4'hF, 1'b0, 1'b1, 8'h00, -1);
      ss = '{0, 0, 0, 0}; ll = '{5, 5, 5, 5};
      burst("post_ovf", 4'hF, 1'b0, 1'b1, 8'h00, -1);

      ss = '{0, 1, 0, 0}; ll = '{5, 4, 0, 0};
      burst("ragged", 4'b0011, 1'b1, 1'b0, 8'h40, -1);

      ss = '{0, 0, 2, 0}; ll = '{1, 0, 2, 0};
      burst("drop", 4'b0101, 1'b0, 1'b1, 8'h00, -1);

      ss = '{0, 0, 0, 0}; ll = '{8, 8, 8, 8};
      burst("midrst", 4'hF, 1'b0, 1'b1, 8'h00, 4);
      ss = '{0, 2, 1, 0}; ll = '{6, 4, 5, 6};
      burst("post_rst", 4'hF, 1'b0, 1'b1, 8'h00, -1);

      for (int b = 0; b < 24; b++) begin
         e = 4'($urandom_range(1, 15));
         f = -1; g = -1;
         for (int i = 0; i < 4; i++)
            if (e[i]) begin
               if (f < 0) f = i;
               g = i;
            end
         ovf = (f != g) && ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 4; i++)
            ss[i] = e[i] ? int'($urandom_range(0, 3)) : 0;
         ss[f] = 0;
         if (ovf) ss[g] = int'($urandom_range(4, 5));
         mxs = 0;
         for (int i = 0; i < 4; i++)
            if (e[i] && ss[i] > mxs) mxs = ss[i];
         for (int i = 0; i < 4; i++)
            ll[i] = e[i] ? mxs - ss[i] + 1 + int'($urandom_range(0, 5)) : 0;
         burst($sformatf("rnd%0d", b), e, 1'($urandom_range(0, 1)),
               1'b1, 8'h00, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/csi_lane_aligner.md
Name: csi_lane_aligner

Overview:
- Per-lane deskew stage that sits directly upstream of the CSI-2 receiver core's byte inputs (rx_valid_hs0..3 / rx_data_hs0..3).
- Takes byte streams from the D-PHY lanes after SoT sync. Each lane may start its HS burst 0..MAX_SKEW byte clocks apart from the others.
- Delays each lane so that the first byte of every enabled lane is presented in the same cycle. Per-lane valids are preserved so legitimate ragged packet ends pass through unchanged.

Parameters:
- NUM_LANES, 4, number of physical lanes.
- LANE_WIDTH, 8, bits per lane byte.
- MAX_SKEW, 3, maximum tolerated inter-lane start skew in byte clocks. Per-lane delay line depth is MAX_SKEW+1.

Ports:
- byte_clk_i  in  1  HS byte clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- lane_en_i  in  NUM_LANES  lane enable mask; sampled only when leaving IDLE.
- lane_valid_i  in  NUM_LANES  per-lane raw HS valid.
- lane_data_i  in  NUM_LANES*LANE_WIDTH  per-lane raw byte; lane i occupies bits [8i+7:8i].
- aligned_valid_o  out  NUM_LANES  per-lane deskewed valid (feeds rx_valid_hsN).
- aligned_data_o  out  NUM_LANES*LANE_WIDTH  per-lane deskewed byte (feeds rx_data_hsN).
- skew_err_o  out  1  one-cycle pulse on an alignment failure.
- aligned_o  out  1  high while in STREAM.

Behaviour:
- Interface: one clock (byte_clk_i). Reset is synchronous and active-high (reset_i).
- Reset values: all outputs 0, state IDLE, delay lines, taps and counters cleared. Reset asserted mid-burst aborts at the next edge; no partial output follows.
- Delay line: per lane, a shift register of {valid, byte}, depth MAX_SKEW+1, shifting every cycle. Index 0 holds the current input.
- Per-lane run counter: counts consecutive cycles the raw valid has been high since leaving IDLE; saturates at MAX_SKEW+1.
- State IDLE: en_q <= lane_en_i every cycle. Go to ALIGN when any lane_valid_i[i] & lane_en_i[i] = 1.
  - If all enabled lanes rise in the same cycle, go directly to STREAM with all taps = 0.
  - lane_en_i = 0 means never leave IDLE.
- State ALIGN: skew counter increments each cycle.
  - When all enabled lanes have run counter >= 1 in the current cycle: tap_i = run_i - 1, go to STREAM.
  - Error conditions: skew counter reaches MAX_SKEW without all lanes valid, OR a lane's valid falls while in ALIGN. On error: skew_err_o = 1 for one cycle, go to ERR.
- State STREAM: aligned_o = 1. Output registers load aligned_valid_o[i] = sr_i[tap_i].valid & en_q[i] and aligned_data_o[i] = sr_i[tap_i].byte.
  - Taps are fixed for the whole burst.
  - Disabled lanes output valid 0 and data 0.
  - The first aligned byte of all enabled lanes appears one cycle after the STREAM-entry cycle.
  - Latency: last-arriving lane = 1 cycle; a lane that arrived k cycles earlier = k+1 cycles.
  - Leave to IDLE the cycle after every enabled tapped valid is 0. Ragged ends (lanes ending 1 cycle apart after alignment) are forwarded unchanged.
- State ERR: outputs held 0. Return to IDLE once all enabled raw valids are 0.
- Data bytes are forwarded regardless of valid. Downstream qualifies data with aligned_valid_o.
- lane_valid_i on a disabled lane is ignored in every state.

Test Plan:
- Zero skew: en=4'hF; all lanes valid together for 8 cycles, lane i bytes = 8'h10*i + n -> aligned_valid_o = 4'hF for exactly 8 cycles starting 1 cycle later, bytes unchanged, skew_err_o never asserted.
- Max skew: lanes 0,1,2,3 rise at cycles 0,1,2,3 (skew 3), each valid 6 cycles, lane-0 first byte 8'hB8 -> all four first bytes emerge in the same cycle (cycle 4), lane 0 shows 8'hB8; aligned_valid_o = 4'hF for 6 cycles.
- Skew overflow: lane 3 rises 4 cycles after lane 0 -> skew_err_o pulses once, aligned_valid_o stays 0; returns to IDLE after all raw valids drop, and a following zero-skew burst aligns normally.
- Two-lane mode with a ragged end: en=4'b0011, lane 1 one cycle late; lane 0 carries 5 bytes, lane 1 carries 4 -> aligned lane 0 valid 5 cycles and lane 1 valid 4 cycles, starting together; lanes 2/3 outputs remain 0 even when their lane_valid_i toggles.
- Premature drop: lane 0 valid 1 cycle then low while lane 2 has not risen -> skew_err_o pulses, no output.
- Reset mid-burst: reset_i high for 1 cycle during STREAM -> the next cycle shows all outputs 0 and IDLE; a new burst afterwards aligns correctly.
